secuenciador_ejecucion: RTL
===========================

// Module: secuenciador_ejecucion
// PURPOSE
// - Synchronous controller sequencing one execution pass of the 5-core phase datapath: walks element-memory
//   addresses 0..lenM-1 and, per address, issues fetch, stage-1/stage-2 enables, serial-register loads and
//   the three serial-port shifts. It drives selDM and reports busy/done.
// - Sits between the orientation/config strobes and the shared core enables. It replaces the gated-clock
//   sequencing with single-clock enables.
// PARAMETERS
// - ADDR_W   7    width of address counter and lenM
// - MEM_LAT  1    cycles memRdEn held before memory data is valid (>=1)
// - TO_W     12   width of the shift watchdog counter (SEQ_TIMEOUT_EN only)
// - TIMEOUT  4000 max cycles waiting for a port done flag (SEQ_TIMEOUT_EN only)
// PORTS
// - clkMC    in  1       master clock; single clock domain
// - rst      in  1       asynchronous, active-high reset
// - sAO      in  1       start strobe (new orientation angles latched), 1-cycle pulse
// - sCfg     in  1       level: configuration valid; start ignored while 0
// - lenM     in  ADDR_W  number of memory words to process
// - sPS      in  3       done flags of serial ports 1..3 (AND of all cores), level
// - regdir   out ADDR_W  current memory address
// - memRdEn  out 1       memory read enable
// - enE1     out 1       stage-1 register enable, 1-cycle pulse
// - enE2     out 1       stage-2 register enable, 1-cycle pulse
// - ldPS     out 3       serial-register parallel-load strobes (one bit per port)
// - enPS     out 3       one-hot serial-port shift enable
// - selDM    out 2       result demux select; equals active port index 0..2
// - flagEjec out 1       busy; high from first FETCH cycle through NEXT of the last address
// - doneEjec out 1       1-cycle pulse at end of pass
// - errTO    out 1       sticky watchdog error (tied 0 without SEQ_TIMEOUT_EN)
// BEHAVIOUR
// - Reset, async and at any time, including mid-pass: state=IDLE and every output 0.
//   This covers regdir, selDM, enPS, ldPS, flagEjec, doneEjec, errTO and the pending bit.
// - States: IDLE, FETCH, E1, E2, LOAD, SHIFT, NEXT, DONE. All outputs are registered (Moore).
// - IDLE: if sAO&sCfg, go to FETCH with regdir=0 and flagEjec=1. If lenM==0 instead, go to DONE with no fetch.
// - FETCH: memRdEn=1 for exactly MEM_LAT cycles, then E1.
// - E1: enE1=1 for one cycle, then E2. E2: enE2=1 for one cycle, then LOAD.
// - LOAD: ldPS=3'b111 for one cycle, then SHIFT with k=0.
// - SHIFT: selDM=k and enPS=1<<k held until sPS[k] is sampled 1. On that edge, k++.
//   After k=2 completes, go to NEXT. sPS[k] already 1 on entry gives a 1-cycle shift.
// - NEXT: regdir<=regdir+1. If regdir+1 >= lenM, go to DONE, else FETCH.
//   Compare at ADDR_W+1 bits so there is no wrap at 2^ADDR_W-1.
// - DONE: doneEjec=1 and flagEjec=0 for one cycle, then IDLE. regdir holds its last value until the next start.
// - Minimum per-address cost at MEM_LAT=1 with immediate sPS: 8 cycles (FETCH, E1, E2, LOAD, 3xSHIFT, NEXT).
// - sAO while not IDLE: sets the pending bit and does not disturb the current pass. DONE with pending=1 and
//   sCfg=1 goes to FETCH directly, skipping IDLE, and clears pending. Repeated sAO pulses collapse into one.
// - sCfg dropping mid-pass: the pass completes. sCfg is only checked at start.
// - lenM change mid-pass: the new value takes effect at the next NEXT compare.
// - sAO and DONE in the same cycle: counts as pending, so a restart follows.
// - enPS is never more than one-hot; ldPS and enPS are never high together.
// CONFIGURATION
// - SEQ_TIMEOUT_EN defined: a watchdog counts cycles in each SHIFT sub-step and is cleared on every k advance.
//   On reaching TIMEOUT: errTO<=1 (sticky until rst), all enables go to 0, and the state goes to DONE.
//   DONE pulses doneEjec; pending is cleared and no auto-restart follows.
// - SEQ_TIMEOUT_EN undefined: no counter logic. SHIFT waits indefinitely, and errTO is constant 0.
// TESTING
// - rst pulse, sCfg=1, lenM=3, sPS tied 3'b111, sAO 1 cycle -> regdir 0,1,2; 24 cycles flagEjec=1; doneEjec one
//   cycle later; regdir ends at 3; exactly 3 enE1 and 3 enE2 pulses.
// - lenM=1, sPS[1] delayed 10 cycles after enPS[1] rises -> enPS=3'b010 and selDM=1 held for 11 cycles, then
//   enPS=3'b100.
// - lenM=0, sAO -> doneEjec within 2 cycles, no memRdEn, flagEjec never 1. sCfg=0 with sAO -> no activity.
// - sAO re-pulsed during address 1 of lenM=4 -> after doneEjec, FETCH starts next cycle with regdir=0 and a second
//   full pass runs.
// - rst asserted during SHIFT k=1 -> all outputs 0 asynchronously; after release the block stays idle until sAO.
// - SEQ_TIMEOUT_EN, TIMEOUT=16, sPS=0 -> enPS=3'b001 for 16 cycles, then errTO=1 and a doneEjec pulse; errTO
//   cleared only by rst.

Source files
------------

// File: rtl/secuenciador_ejecucion.sv
// Execution-pass sequencer: walks addresses 0..lenM-1 issuing fetch/stage/load/shift enables on one clock.
// Optional SHIFT watchdog enabled by defining SEQ_TIMEOUT_EN.
module secuenciador_ejecucion #(
  parameter int ADDR_W  = 7,
  parameter int MEM_LAT = 1,
  parameter int TO_W    = 12,
  parameter int TIMEOUT = 4000
) (
  input  logic              clkMC,
  input  logic              rst,
  input  logic              sAO,
  input  logic              sCfg,
  input  logic [ADDR_W-1:0] lenM,
  input  logic [2:0]        sPS,
  output logic [ADDR_W-1:0] regdir,
  output logic              memRdEn,
  output logic              enE1,
  output logic              enE2,
  output logic [2:0]        ldPS,
  output logic [2:0]        enPS,
  output logic [1:0]        selDM,
  output logic              flagEjec,
  output logic              doneEjec,
  output logic              errTO
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] E1    = 3'd2;
  localparam logic [2:0] E2    = 3'd3;
  localparam logic [2:0] LOAD  = 3'd4;
  localparam logic [2:0] SHIFT = 3'd5;
  localparam logic [2:0] NEXT  = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  if (MEM_LAT < 1 || TIMEOUT < 1 || TIMEOUT > (1 << TO_W)) begin : gParamCheck
    $error("secuenciador_ejecucion: MEM_LAT/TIMEOUT/TO_W out of range");
  end

  logic [2:0]        state, stateN;
  logic [1:0]        k, kN;
  logic [LAT_W-1:0]  latCnt, latN;
  logic [ADDR_W-1:0] regdirN;
  logic              pending, pendN;
  logic              abortTO;
  logic              startOk;
  logic              toHit;
  logic [ADDR_W:0]   addrNext;

`ifdef SEQ_TIMEOUT_EN
  logic [TO_W-1:0] toCnt;

  // Counts only while the active port has not reported done; any advance or exit restarts it.
  assign toHit = (state == SHIFT) && !sPS[k] && (toCnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clkMC or posedge rst) begin
    if (rst)                          toCnt <= '0;
    else if (state == SHIFT && !sPS[k]) toCnt <= toCnt + 1'b1;
    else                              toCnt <= '0;
  end
`else
  assign toHit = 1'b0;
`endif

  always_comb begin
    stateN   = state;
    kN       = k;
    latN     = latCnt;
    regdirN  = regdir;
    pendN    = pending | (sAO && (state != IDLE));
    startOk  = 1'b0;
    addrNext = {1'b0, regdir} + (ADDR_W+1)'(1);
    case (state)
      IDLE:  startOk = sAO && sCfg;
      FETCH: begin
        if (latCnt == LAT_W'(MEM_LAT - 1)) stateN = E1;
        else                               latN   = latCnt + 1'b1;
      end
      E1:    stateN = E2;
      E2:    stateN = LOAD;
      LOAD: begin
        stateN = SHIFT;
        kN     = 2'd0;
      end
      SHIFT: begin
        if (toHit) begin
          stateN = DONE;
          pendN  = 1'b0;
        end else if (sPS[k]) begin
          if (k == 2'd2) stateN = NEXT;
          else           kN     = k + 2'd1;
        end
      end
      NEXT: begin
        regdirN = regdir + 1'b1;
        latN    = '0;
        stateN  = (addrNext >= {1'b0, lenM}) ? DONE : FETCH;
      end
      DONE: begin
        pendN = 1'b0;
        // A start seen during the pass (or in this very cycle) chains straight into the next pass.
        if (!abortTO && (pending || sAO) && sCfg) startOk = 1'b1;
        else                                       stateN  = IDLE;
      end
      default: stateN = IDLE;
    endcase
    if (startOk) begin
      regdirN = '0;
      latN    = '0;
      pendN   = 1'b0;
      stateN  = (lenM == '0) ? DONE : FETCH;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with the state they describe.
  always_ff @(posedge clkMC or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= 2'd0;
      latCnt   <= '0;
      regdir   <= '0;
      pending  <= 1'b0;
      abortTO  <= 1'b0;
      memRdEn  <= 1'b0;
      enE1     <= 1'b0;
      enE2     <= 1'b0;
      ldPS     <= 3'b000;
      enPS     <= 3'b000;
      selDM    <= 2'd0;
      flagEjec <= 1'b0;
      doneEjec <= 1'b0;
      errTO    <= 1'b0;
    end else begin
      state    <= stateN;
      k        <= kN;
      latCnt   <= latN;
      regdir   <= regdirN;
      pending  <= pendN;
      abortTO  <= toHit;
      memRdEn  <= (stateN == FETCH);
      enE1     <= (stateN == E1);
      enE2     <= (stateN == E2);
      ldPS     <= {3{stateN == LOAD}};
      enPS     <= (stateN == SHIFT) ? (3'b001 << kN) : 3'b000;
      selDM    <= (stateN == SHIFT) ? kN : 2'd0;
      flagEjec <= (stateN != IDLE) && (stateN != DONE);
      doneEjec <= (stateN == DONE);
      errTO    <= errTO | toHit;
    end
  end

endmodule
